reserve_table: RTL

- Multi-channel load-reserve / store-conditional reservation unit (lwarx/stwcx.) for the MEM stage.
- Generalises the single-reservation block to NUM_CH hardware contexts, each with its own reservation.
- Adds three capabilities: cross-channel and external snoop invalidation, a programmable address granule, and a strict mode for the mismatch case.
- Produces the store-enable mask and the CR0 update for the issuing channel.

---
 rtl/reserve_table_pkg.sv | 20 ++
 rtl/reserve_table_entry.sv | 69 ++++++
 rtl/reserve_table.sv | 109 ++++++++++
 3 files changed

// File: rtl/reserve_table_pkg.sv
// Shared encodings for the reservation unit: op codes, CR/XER field positions, CR0 builder.
package reserve_table_pkg;
    localparam int RESERVE_OP_W = 3;
    localparam int CR_WIDTH     = 32;
    localparam int SPR_WIDTH    = 32;
    localparam int XER_SO_BIT   = 0;

    typedef enum logic [RESERVE_OP_W-1:0] {
        OP_NONE = 3'd0,
        OP_LD   = 3'd1,
        OP_ST   = 3'd2,
        OP_WR   = 3'd3,
        OP_CLR  = 3'd4
    } reserve_op_e;

    // CR0 = {LT, GT, EQ, SO}; a conditional store never reports LT/GT.
    function automatic logic [0:3] cr0_field(input logic eq, input logic so);
        return {2'b00, eq, so};
    endfunction
endpackage

// File: rtl/reserve_table_entry.sv
// One reservation channel: valid/length/granule state, snoop self-clear and compare outputs.
// With RESERVE_TIMEOUT_EN defined, a per-channel lifetime counter retires stale reservations.
module reserve_entry #(
    parameter int ADDR_W      = 32,
    parameter int GRAN_BITS   = 2,
    parameter int TIMEOUT_CYC = 1024
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          set,
    input  logic                          clr,
    input  logic                          snoop,
    input  logic [0:3]                    op_len,
    input  logic [0:ADDR_W-GRAN_BITS-1]   op_gaddr,
    input  logic [0:ADDR_W-GRAN_BITS-1]   snoop_gaddr,
    output logic                          valid,
    output logic                          live,
    output logic                          len_hit,
    output logic                          ghit
);
    logic [0:3]                  len_q;
    logic [0:ADDR_W-GRAN_BITS-1] gaddr_q;
    logic                        snoop_hit;
    logic                        expired;
    logic                        expire_next;

    assign snoop_hit = snoop && valid && (gaddr_q == snoop_gaddr);
    assign ghit      = valid && (gaddr_q == op_gaddr);
    assign len_hit   = (len_q == op_len);
    // A same-cycle snoop or an expired timer already counts as lost for this cycle's ST.
    assign live      = valid && !snoop_hit && !expired;

`ifdef RESERVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    assign expired     = valid && (cnt == CNT_W'(TIMEOUT_CYC));
    assign expire_next = valid && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (set)
            cnt <= '0;
        else if (valid && cnt != CNT_W'(TIMEOUT_CYC))
            cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign expired        = 1'b0;
    assign expire_next    = 1'b0;
`endif

    // A load always wins over any clear source in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            len_q   <= '0;
            gaddr_q <= '0;
        end else if (set) begin
            valid   <= 1'b1;
            len_q   <= op_len;
            gaddr_q <= op_gaddr;
        end else if (clr || snoop_hit || expire_next) begin
            valid   <= 1'b0;
        end
    end
endmodule

// File: rtl/reserve_table.sv
// Multi-channel lwarx/stwcx. reservation unit: per-channel entries, store qualification and CR0.
// Optional reservation lifetime timer enabled by defining RESERVE_TIMEOUT_EN.
module reserve_table
    import reserve_table_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int ADDR_W      = 32,
    parameter int GRAN_BITS   = 2,
    parameter int STRICT      = 0,
    parameter int TIMEOUT_CYC = 1024
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RESERVE_OP_W-1:0] Op,
    input  logic [CH_W-1:0]         CH_ID,
    input  logic [0:3]              RESERVE_LENGTH,
    input  logic [0:ADDR_W-1]       RESERVE_ADDR,
    input  logic [0:CR_WIDTH-1]     CRrd,
    input  logic [0:SPR_WIDTH-1]    XERrd,
    input  logic                    SNOOP_VALID,
    input  logic [0:ADDR_W-1]       SNOOP_ADDR,
    output logic [0:CR_WIDTH-1]     CRwd,
    output logic                    DMWr_mask,
    output logic [NUM_CH-1:0]       RESERVE_VALID
);
    localparam int GA_W = ADDR_W - GRAN_BITS;

    logic [0:GA_W-1]   op_gaddr, snoop_gaddr;
    reserve_op_e       op;
    logic [NUM_CH-1:0] ch_sel, live, len_hit, ghit, set, clr;
    logic              sel_live, st_match, store_done, eq, cr_upd;

    assign op_gaddr    = RESERVE_ADDR[0:GA_W-1];
    assign snoop_gaddr = SNOOP_ADDR[0:GA_W-1];

    logic unused_bits;
    assign unused_bits = ^{RESERVE_ADDR[GA_W:ADDR_W-1], SNOOP_ADDR[GA_W:ADDR_W-1],
                           CRrd[0:3], XERrd};

    // Out-of-range channel ids degrade to a no-op.
    always_comb begin
        op = OP_NONE;
        if (int'(CH_ID) < NUM_CH)
            op = reserve_op_e'(Op);
        for (int k = 0; k < NUM_CH; k++)
            ch_sel[k] = (int'(CH_ID) == k);
    end

    assign sel_live = |(ch_sel & live);
    assign st_match = sel_live && |(ch_sel & len_hit) && |(ch_sel & ghit);

    // DMWr_mask also qualifies LD/NONE cycles, so it defaults high.
    always_comb begin
        DMWr_mask  = 1'b1;
        eq         = 1'b0;
        cr_upd     = 1'b0;
        store_done = 1'b0;
        set        = '0;
        clr        = '0;
        case (op)
            OP_LD:  set = ch_sel;
            OP_ST: begin
                cr_upd = 1'b1;
                clr    = ch_sel;
                if (st_match)
                    eq = 1'b1;
                else if (!sel_live || STRICT != 0)
                    eq = 1'b0;
                else
                    eq = 1'b1;
                DMWr_mask  = eq;
                store_done = eq;
            end
            OP_WR:  store_done = 1'b1;
            OP_CLR: clr = ch_sel;
            default: ;
        endcase
        // Any store that reaches memory kills other channels' reservations on that granule.
        if (store_done)
            clr = clr | (ghit & ~ch_sel);
    end

    assign CRwd = cr_upd ? {cr0_field(eq, XERrd[XER_SO_BIT]), CRrd[4:CR_WIDTH-1]} : CRrd;

    logic [NUM_CH-1:0] valid;
    assign RESERVE_VALID = valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        reserve_entry #(
            .ADDR_W      (ADDR_W),
            .GRAN_BITS   (GRAN_BITS),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .set         (set[k]),
            .clr         (clr[k]),
            .snoop       (SNOOP_VALID),
            .op_len      (RESERVE_LENGTH),
            .op_gaddr    (op_gaddr),
            .snoop_gaddr (snoop_gaddr),
            .valid       (valid[k]),
            .live        (live[k]),
            .len_hit     (len_hit[k]),
            .ghit        (ghit[k])
        );
    end
endmodule
